cpu_mem_loader: RTL and testbench
=================================

Name: cpu_mem_loader

Overview:
- Host-side controller that drives the CPU's external memory ports: the ext write/read ports of instruction memory (32-bit) and data memory (64-bit), plus the CPU `enable`.
- Consumes a 64-bit command/data stream over a valid/ready handshake.
- Writes program and data images into memory, dumps memory back over an output stream, and starts/stops CPU execution.
- Sits between the testbench/host link and the cpu top-level ports.

Parameters:
- DATA_W, 64, stream word width and data-memory word width.
- IMEM_W, 32, instruction word width.
- CNT_W, 29, width of the header word-count field.

Ports:
- clk  input  1  main clock.
- arst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  command/data word valid.
- in_ready  output  1  loader accepts in_data this cycle.
- in_data  input  64  header or payload word.
- out_valid  output  1  dump word valid.
- out_ready  input  1  host accepts out_data.
- out_data  output  64  dumped word; imem words are zero-extended.
- cpu_enable  output  1  drives cpu `enable`.
- busy  output  1  high in any state other than IDLE.
- cmd_err  output  1  sticky; set by an illegal opcode.
- addr_ext  output  64  imem ext byte address.
- wen_ext  output  1  imem ext write enable.
- ren_ext  output  1  imem ext read enable.
- wdata_ext  output  32  imem ext write data.
- rdata_ext  input  32  imem ext read data.
- addr_ext_2  output  64  dmem ext byte address.
- wen_ext_2  output  1  dmem ext write enable.
- ren_ext_2  output  1  dmem ext read enable.
- wdata_ext_2  output  64  dmem ext write data.
- rdata_ext_2  input  64  dmem ext read data.

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset asserted mid-operation aborts immediately: no partial strobe completes and any pending count is discarded.
- Header format:
  - [63:61] opcode: 000 LOAD_I, 001 LOAD_D, 010 DUMP_I, 011 DUMP_D, 100 START, 101 STOP; all others are illegal.
  - [60:32] count N, in words.
  - [31:0] base byte address, zero-extended to 64 bits.
- Address stride: +4 per word for imem, +8 per word for dmem. The address counter wraps modulo 2^64 with no checking.
- Both memories have a synchronous read port: rdata is valid the cycle after ren is high.
- FSM states: IDLE, LOAD, RD_REQ, RD_WAIT, RD_OUT.
- IDLE:
  - in_ready=1.
  - On a header handshake:
    - LOAD_x with N>0 -> LOAD.
    - DUMP_x with N>0 -> RD_REQ.
    - Either with N=0 -> stay IDLE, no memory access.
    - START -> cpu_enable=1 from the next cycle.
    - STOP -> cpu_enable=0 from the next cycle.
    - Illegal opcode -> cmd_err=1, stay IDLE.
  - Any accepted LOAD/DUMP header clears cpu_enable on the next cycle, so the CPU is never running while the loader touches memory.
- LOAD:
  - in_ready=1.
  - Each payload handshake produces, on the next cycle, a single-cycle wen_ext (or wen_ext_2) with registered addr/wdata. LOAD_I takes in_data[31:0].
  - Back-to-back handshakes give back-to-back write strobes, one per cycle.
  - After the Nth payload word -> IDLE.
- RD_REQ: in_ready=0; ren high for one cycle at the current address -> RD_WAIT.
- RD_WAIT: capture rdata into the out_data register -> RD_OUT.
- RD_OUT:
  - out_valid=1; out_data is held stable until out_ready.
  - On handshake: decrement the remaining count, advance the address, then go to RD_REQ if words remain, else IDLE.
  - Throughput is 1 word per 3 cycles with out_ready tied high.
- Strobe exclusivity: wen and ren are never both high, and imem and dmem ports are never strobed in the same cycle.
- Idle port values: ext addr and wdata hold their last value when not strobing.
- busy equals (state != IDLE).
- cmd_err clears only on reset.

Test Plan:
- Reset, then LOAD_I header base=0x100 N=3, payloads 0x13,0x93,0x113 streamed with in_valid held high -> three consecutive wen_ext pulses at addr 0x100/0x104/0x108 with data 0x13/0x93/0x113; then busy=0 and no further strobes.
- LOAD_D base=0x0 N=2, payloads 0xDEADBEEF00000001 and 0x2 with in_valid gaps of 2 cycles -> wen_ext_2 at 0x0 and 0x8 only on the cycles following each handshake.
- DUMP_D base=0x0 N=2 against the model memory from the previous test, out_ready low for 5 cycles -> out_data=0xDEADBEEF00000001 held stable with out_valid=1; then 0x2; ren_ext_2 pulses exactly twice.
- START -> cpu_enable=1 after one cycle. A subsequent LOAD_I header -> cpu_enable=0 on the cycle after acceptance, before the first wen_ext.
- Header with opcode 111 -> cmd_err=1, no memory strobes, next valid command still executes. LOAD_D with N=0 -> no wen_ext_2, busy stays 0.
- arst_n pulled low in LOAD after 1 of 4 words -> all outputs 0 asynchronously; after release, in_ready=1 and the next word is parsed as a header.

Source files
------------

// File: rtl/cpu_mem_loader.sv
// Host-side loader: streams program/data images into the CPU's external memory
// ports, dumps memory back over an output stream, and gates the CPU enable.
module cpu_mem_loader #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned IMEM_W = 32,
    parameter int unsigned CNT_W  = 29
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              cpu_enable,
    output logic              busy,
    output logic              cmd_err,
    output logic [63:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [IMEM_W-1:0] wdata_ext,
    input  logic [IMEM_W-1:0] rdata_ext,
    output logic [63:0]       addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_OUT
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD_I = 3'b000,
        OP_LOAD_D = 3'b001,
        OP_DUMP_I = 3'b010,
        OP_DUMP_D = 3'b011,
        OP_START  = 3'b100,
        OP_STOP   = 3'b101
    } op_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CNT_W-1:0]    r_cnt;
    logic [63:0]         r_addr;
    logic                r_is_d;
    logic                r_in_ready;
    logic                r_cpu_en;
    logic                r_cmd_err;
    logic [DATA_W-1:0]   r_out_data;

    logic [63:0]         r_addr_i;
    logic                r_wen_i;
    logic                r_ren_i;
    logic [IMEM_W-1:0]   r_wdata_i;
    logic [63:0]         r_addr_d;
    logic                r_wen_d;
    logic                r_ren_d;
    logic [DATA_W-1:0]   r_wdata_d;

    logic [2:0]          w_op;
    logic [CNT_W-1:0]    w_hdr_cnt;
    logic [63:0]         w_hdr_base;
    logic                w_hdr_cnt_nz;
    logic                w_hs_in;
    logic                w_hs_out;
    logic                w_last;
    logic [63:0]         w_stride;
    logic [63:0]         w_addr_adv;

    logic                w_hdr_load;
    logic                w_hdr_dump;
    logic                w_rd_issue;
    logic                w_rd_is_d;
    logic [63:0]         w_rd_addr;
    logic                w_wr_issue;

    assign w_op         = in_data[63:61];
    assign w_hdr_cnt    = in_data[60:32];
    assign w_hdr_base   = {32'b0, in_data[31:0]};
    assign w_hdr_cnt_nz = (w_hdr_cnt != '0);
    assign w_hs_in      = in_valid & r_in_ready;
    assign w_hs_out     = (r_state == S_RD_OUT) & out_ready;
    assign w_last       = (r_cnt == CNT_W'(1));
    assign w_stride     = r_is_d ? 64'd8 : 64'd4;
    assign w_addr_adv   = r_addr + w_stride;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hdr_load  = 1'b0;
        w_hdr_dump  = 1'b0;
        w_rd_issue  = 1'b0;
        w_rd_is_d   = r_is_d;
        w_rd_addr   = w_addr_adv;
        w_wr_issue  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hs_in) begin
                    case (w_op)
                        OP_LOAD_I, OP_LOAD_D: begin
                            w_hdr_load = 1'b1;
                            if (w_hdr_cnt_nz) w_state_nxt = S_LOAD;
                        end
                        OP_DUMP_I, OP_DUMP_D: begin
                            w_hdr_dump = 1'b1;
                            if (w_hdr_cnt_nz) begin
                                w_state_nxt = S_RD_REQ;
                                w_rd_issue  = 1'b1;
                                w_rd_is_d   = w_op[0];
                                w_rd_addr   = w_hdr_base;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_LOAD: begin
                if (w_hs_in) begin
                    w_wr_issue = 1'b1;
                    if (w_last) w_state_nxt = S_IDLE;
                end
            end
            S_RD_REQ:  w_state_nxt = S_RD_WAIT;
            S_RD_WAIT: w_state_nxt = S_RD_OUT;
            S_RD_OUT: begin
                if (w_hs_out) begin
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_RD_REQ;
                        w_rd_issue  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read strobes are registered on entry to RD_REQ so ren and addr are
    // presented exactly during the RD_REQ cycle; rdata then lands in RD_WAIT.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_is_d     <= 1'b0;
            r_in_ready <= 1'b0;
            r_cpu_en   <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_out_data <= '0;
            r_addr_i   <= '0;
            r_wen_i    <= 1'b0;
            r_ren_i    <= 1'b0;
            r_wdata_i  <= '0;
            r_addr_d   <= '0;
            r_wen_d    <= 1'b0;
            r_ren_d    <= 1'b0;
            r_wdata_d  <= '0;
        end else begin
            r_wen_i    <= 1'b0;
            r_ren_i    <= 1'b0;
            r_wen_d    <= 1'b0;
            r_ren_d    <= 1'b0;
            r_in_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);

            if (r_state == S_IDLE && w_hs_in) begin
                case (w_op)
                    OP_LOAD_I, OP_LOAD_D, OP_DUMP_I, OP_DUMP_D: begin
                        r_cpu_en <= 1'b0;
                        r_cnt    <= w_hdr_cnt;
                        r_addr   <= w_hdr_base;
                        r_is_d   <= w_op[0];
                    end
                    OP_START: r_cpu_en  <= 1'b1;
                    OP_STOP:  r_cpu_en  <= 1'b0;
                    default:  r_cmd_err <= 1'b1;
                endcase
            end

            if (w_wr_issue) begin
                r_cnt  <= r_cnt - CNT_W'(1);
                r_addr <= w_addr_adv;
                if (r_is_d) begin
                    r_wen_d   <= 1'b1;
                    r_addr_d  <= r_addr;
                    r_wdata_d <= in_data;
                end else begin
                    r_wen_i   <= 1'b1;
                    r_addr_i  <= r_addr;
                    r_wdata_i <= in_data[IMEM_W-1:0];
                end
            end

            if (r_state == S_RD_WAIT) begin
                r_out_data <= r_is_d ? rdata_ext_2 : {{(DATA_W-IMEM_W){1'b0}}, rdata_ext};
            end

            if (w_hs_out) begin
                r_cnt  <= r_cnt - CNT_W'(1);
                r_addr <= w_addr_adv;
            end

            if (w_rd_issue) begin
                if (w_rd_is_d) begin
                    r_ren_d  <= 1'b1;
                    r_addr_d <= w_rd_addr;
                end else begin
                    r_ren_i  <= 1'b1;
                    r_addr_i <= w_rd_addr;
                end
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state == S_RD_OUT);
    assign out_data    = r_out_data;
    assign cpu_enable  = r_cpu_en;
    assign busy        = (r_state != S_IDLE);
    assign cmd_err     = r_cmd_err;
    assign addr_ext    = r_addr_i;
    assign wen_ext     = r_wen_i;
    assign ren_ext     = r_ren_i;
    assign wdata_ext   = r_wdata_i;
    assign addr_ext_2  = r_addr_d;
    assign wen_ext_2   = r_wen_d;
    assign ren_ext_2   = r_ren_d;
    assign wdata_ext_2 = r_wdata_d;

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Directed bench for cpu_mem_loader with behavioural imem/dmem models and a strobe log.
module tb_cpu_mem_loader;

    logic        clk;
    logic        arst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        cpu_enable;
    logic        busy;
    logic        cmd_err;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2;

    cpu_mem_loader #(.DATA_W(64), .IMEM_W(32), .CNT_W(29)) dut (
        .clk(clk), .arst_n(arst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cpu_enable(cpu_enable), .busy(busy), .cmd_err(cmd_err),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] imem [0:255];
    logic [63:0] dmem [0:255];

    always @(posedge clk) begin
        if (wen_ext)   imem[addr_ext[9:2]]    <= wdata_ext;
        if (ren_ext)   rdata_ext              <= imem[addr_ext[9:2]];
        if (wen_ext_2) dmem[addr_ext_2[10:3]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2            <= dmem[addr_ext_2[10:3]];
    end

    // kind bits: {wen_ext, ren_ext, wen_ext_2, ren_ext_2}
    typedef struct {
        int          cyc;
        logic [3:0]  kind;
        logic [63:0] addr;
        logic [63:0] data;
    } ev_t;

    ev_t log_q[$];
    int  cyc;
    int  viol;

    initial cyc = 0;
    initial viol = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wen_ext || ren_ext || wen_ext_2 || ren_ext_2) begin
            ev_t e;
            e.cyc  = cyc;
            e.kind = {wen_ext, ren_ext, wen_ext_2, ren_ext_2};
            e.addr = (wen_ext || ren_ext) ? addr_ext : addr_ext_2;
            e.data = wen_ext ? {32'b0, wdata_ext} : wdata_ext_2;
            log_q.push_back(e);
            if ((wen_ext && ren_ext) || (wen_ext_2 && ren_ext_2) ||
                ((wen_ext || ren_ext) && (wen_ext_2 || ren_ext_2)))
                viol = viol + 1;
        end
    end

    int checks;
    int errors;
    int hs_cyc;
    int base;
    int hs1;
    int hs2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [63:0] w);
        logic done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 30 && !done; i++) begin
            done = in_ready;
            @(posedge clk);
            #1;
        end
        hs_cyc = cyc;
        if (!done) chk("send_timeout", 64'(done), 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = '0;
        tick(n);
    endtask

    task automatic wait_out(input string tag);
        for (int i = 0; i < 40 && !out_valid; i++) tick(1);
        chk(tag, 64'(out_valid), 64'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        arst_n    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            imem[i] = '0;
            dmem[i] = '0;
        end

        // Reset state
        #12;
        chk("rst_ctrl", 64'({in_ready, out_valid, cpu_enable, busy, cmd_err,
                             wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
        chk("rst_addr", addr_ext | addr_ext_2 | out_data, 64'd0);
        #11 arst_n = 1'b1;
        tick(2);
        chk("rst_ready", 64'(in_ready), 64'd1);

        // LOAD_I base 0x100 N=3, back-to-back payloads
        base = log_q.size();
        send(64'h0000_0003_0000_0100);
        send(64'h13);
        hs1 = hs_cyc;
        send(64'h93);
        send(64'h113);
        idle(4);
        chk("li_nstrobe", 64'(log_q.size() - base), 64'd3);
        if (log_q.size() - base == 3) begin
            chk("li_kind0", 64'(log_q[base].kind),   64'h8);
            chk("li_addr0", log_q[base].addr,        64'h100);
            chk("li_addr1", log_q[base+1].addr,      64'h104);
            chk("li_addr2", log_q[base+2].addr,      64'h108);
            chk("li_data0", log_q[base].data,        64'h13);
            chk("li_data1", log_q[base+1].data,      64'h93);
            chk("li_data2", log_q[base+2].data,      64'h113);
            chk("li_cyc0",  64'(log_q[base].cyc),    64'(hs1));
            chk("li_b2b",   64'(log_q[base+2].cyc - log_q[base].cyc), 64'd2);
        end
        chk("li_busy", 64'(busy), 64'd0);

        // LOAD_D base 0 N=2 with gaps
        base = log_q.size();
        send(64'h2000_0002_0000_0000);
        idle(2);
        send(64'hDEAD_BEEF_0000_0001);
        hs1 = hs_cyc;
        idle(2);
        send(64'h2);
        hs2 = hs_cyc;
        idle(3);
        chk("ld_nstrobe", 64'(log_q.size() - base), 64'd2);
        if (log_q.size() - base == 2) begin
            chk("ld_kind0", 64'(log_q[base].kind),   64'h2);
            chk("ld_addr0", log_q[base].addr,        64'h0);
            chk("ld_addr1", log_q[base+1].addr,      64'h8);
            chk("ld_data0", log_q[base].data,        64'hDEAD_BEEF_0000_0001);
            chk("ld_data1", log_q[base+1].data,      64'h2);
            chk("ld_cyc0",  64'(log_q[base].cyc),    64'(hs1));
            chk("ld_cyc1",  64'(log_q[base+1].cyc),  64'(hs2));
        end

        // DUMP_D base 0 N=2 with backpressure
        base = log_q.size();
        send(64'h6000_0002_0000_0000);
        idle(0);
        chk("dd_ready_low", 64'(in_ready), 64'd0);
        wait_out("dd_valid0");
        chk("dd_data0", out_data, 64'hDEAD_BEEF_0000_0001);
        tick(5);
        chk("dd_hold_valid", 64'(out_valid), 64'd1);
        chk("dd_hold_data", out_data, 64'hDEAD_BEEF_0000_0001);
        out_ready = 1'b1;
        tick(1);
        wait_out("dd_valid1");
        chk("dd_data1", out_data, 64'h2);
        tick(1);
        out_ready = 1'b0;
        tick(2);
        chk("dd_busy", 64'(busy), 64'd0);
        chk("dd_nstrobe", 64'(log_q.size() - base), 64'd2);
        if (log_q.size() - base == 2) begin
            chk("dd_kind0", 64'(log_q[base].kind),   64'h1);
            chk("dd_kind1", 64'(log_q[base+1].kind), 64'h1);
            chk("dd_addr1", log_q[base+1].addr,      64'h8);
        end

        // START, then LOAD_I header drops enable before any write
        send(64'h8000_0000_0000_0000);
        chk("start_en", 64'(cpu_enable), 64'd1);
        base = log_q.size();
        send(64'h0000_0001_0000_0200);
        chk("load_dis_en", 64'(cpu_enable), 64'd0);
        chk("load_dis_nostrobe", 64'(log_q.size() - base), 64'd0);
        send(64'hABC);
        idle(3);
        chk("li2_nstrobe", 64'(log_q.size() - base), 64'd1);
        if (log_q.size() - base == 1)
            chk("li2_addr", log_q[base].addr, 64'h200);

        // Illegal opcode, then START still executes; LOAD_D N=0 is a no-op
        base = log_q.size();
        send(64'hE000_0000_0000_0000);
        idle(2);
        chk("ill_err", 64'(cmd_err), 64'd1);
        chk("ill_busy", 64'(busy), 64'd0);
        send(64'h8000_0000_0000_0000);
        chk("ill_next_cmd", 64'(cpu_enable), 64'd1);
        send(64'h2000_0000_0000_0010);
        chk("n0_busy_imm", 64'(busy), 64'd0);
        chk("n0_cpu_dis", 64'(cpu_enable), 64'd0);
        idle(3);
        chk("n0_busy", 64'(busy), 64'd0);
        chk("n0_nostrobe", 64'(log_q.size() - base), 64'd0);
        chk("ill_sticky", 64'(cmd_err), 64'd1);

        // Async reset in LOAD_D after 1 of 4 words
        base = log_q.size();
        send(64'h2000_0004_0000_0040);
        send(64'h55);
        idle(1);
        chk("ar_busy_pre", 64'(busy), 64'd1);
        #2 arst_n = 1'b0;
        #1;
        chk("ar_ctrl", 64'({in_ready, out_valid, cpu_enable, busy, cmd_err,
                            wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
        chk("ar_addr", addr_ext | addr_ext_2 | out_data, 64'd0);
        chk("ar_wdata", {32'b0, wdata_ext} | wdata_ext_2, 64'd0);
        #20 arst_n = 1'b1;
        tick(2);
        chk("ar_ready", 64'(in_ready), 64'd1);
        chk("ar_busy", 64'(busy), 64'd0);
        send(64'h4000_0001_0000_0100);
        idle(0);
        wait_out("ar_hdr_valid");
        chk("ar_hdr_data", out_data, 64'h13);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(1);
        chk("ar_done_busy", 64'(busy), 64'd0);
        chk("ar_nstrobe", 64'(log_q.size() - base), 64'd2);
        if (log_q.size() - base == 2) begin
            chk("ar_wr_kind", 64'(log_q[base].kind), 64'h2);
            chk("ar_rd_kind", 64'(log_q[base+1].kind), 64'h4);
        end

        chk("strobe_excl", 64'(viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
